// File: rtl/axi_read_issue_ctrl.sv
// Splits one read transfer into AXI AR bursts and tracks in-flight bursts via rlast handshakes.
// First arvalid one cycle after start; issue stalls while C_MAX_OUTSTANDING bursts await rlast.
module axi_read_issue_ctrl #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         ctrl_start,
  output logic                         ctrl_done,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  input  logic                         m_axi_rvalid,
  input  logic                         m_axi_rready,
  input  logic                         m_axi_rlast,
  output logic                         busy
);

  localparam int BYTES = C_DATA_WIDTH / 8;
  // One spare bit so the ceil() rounding additions cannot overflow.
  localparam int CW = C_XFER_SIZE_WIDTH + 1;
  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * BYTES);
  localparam logic [7:0]              FULL_LEN    = 8'(C_BURST_LEN - 1);
  localparam logic [OW-1:0]           MAX_OUT     = OW'(C_MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [7:0]              last_len_q, last_len_d;
  logic [CW-1:0]           ar_rem_q, ar_rem_d;
  logic [CW-1:0]           r_rem_q, r_rem_d;
  logic [OW-1:0]           outst_q, outst_d;

  logic [CW-1:0] start_beats;
  logic [CW-1:0] start_bursts;
  logic [7:0]    start_last_len;
  logic          ar_hs;
  logic          rlast_hs;

  assign start_beats    = (CW'(ctrl_xfer_size_in_bytes) + CW'(BYTES - 1)) / CW'(BYTES);
  assign start_bursts   = (start_beats + CW'(C_BURST_LEN - 1)) / CW'(C_BURST_LEN);
  // Equals beats - (N-1)*C_BURST_LEN - 1 whenever beats is non-zero.
  assign start_last_len = 8'((start_beats - CW'(1)) % CW'(C_BURST_LEN));

  assign m_axi_arvalid = (state_q == RUN) && (ar_rem_q != '0) && (outst_q != MAX_OUT);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign ctrl_done     = (state_q == DONE);
  assign busy          = (state_q != IDLE);

  assign ar_hs    = m_axi_arvalid && m_axi_arready;
  assign rlast_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    last_len_d = last_len_q;
    ar_rem_d   = ar_rem_q;
    r_rem_d    = r_rem_q;
    outst_d    = outst_q;
    case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          araddr_d   = ctrl_addr_offset;
          last_len_d = start_last_len;
          arlen_d    = (start_bursts == CW'(1)) ? start_last_len : FULL_LEN;
          ar_rem_d   = start_bursts;
          r_rem_d    = start_bursts;
          outst_d    = '0;
          state_d    = (start_beats == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (ar_hs) begin
          ar_rem_d = ar_rem_q - CW'(1);
          araddr_d = araddr_q + BURST_BYTES;
          arlen_d  = (ar_rem_q == CW'(2)) ? last_len_q : FULL_LEN;
        end
        // A stray rlast with nothing left to return saturates rather than wraps.
        if (rlast_hs && (r_rem_q != '0)) begin
          r_rem_d = r_rem_q - CW'(1);
        end
        case ({ar_hs, rlast_hs})
          2'b10:   outst_d = outst_q + OW'(1);
          2'b01:   outst_d = (outst_q != '0) ? outst_q - OW'(1) : outst_q;
          default: outst_d = outst_q;
        endcase
        if ((ar_rem_d == '0) && (r_rem_d == '0)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      araddr_q   <= '0;
      arlen_q    <= '0;
      last_len_q <= '0;
      ar_rem_q   <= '0;
      r_rem_q    <= '0;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      last_len_q <= last_len_d;
      ar_rem_q   <= ar_rem_d;
      r_rem_q    <= r_rem_d;
      outst_q    <= outst_d;
    end
  end

endmodule
